// File: rtl/onehot_scan_decoder.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with output enable.
// Modes: 00 direct (latched) decode, 01 single-cycle pulse decode,
//        10 dwell-timed walking-one scan up, 11 walking-one scan down.
// A load always captures sel into the index and restarts the dwell count.
module onehot_scan_decoder #(
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    load,
  output logic [(1<<SEL_W)-1:0]   F,
  output logic [SEL_W-1:0]        idx,
  output logic                    wrap
);

  localparam int OUT_W = 1 << SEL_W;
  // The dwell counter needs at least one bit even when DWELL is 1.
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_TOP  = {SEL_W{1'b1}};

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_PULSE  = 2'b01;
  localparam logic [1:0] MODE_UP     = 2'b10;

  logic [SEL_W-1:0] idx_q,  idx_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [OUT_W-1:0] f_q,    f_d;
  logic             wrap_q, wrap_d;

  logic scan_mode;
  logic dwell_done;

  assign scan_mode  = mode[1];
  assign dwell_done = (cnt_q == CNT_LAST);

  // Next-state logic for index, dwell counter, wrap flag and one-hot output.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    f_d    = '0;

    if (load) begin
      // Load wins over any scan advance and never reports a wrap.
      idx_d = sel;
      cnt_d = '0;
    end else if (scan_mode && en) begin
      if (dwell_done) begin
        cnt_d = '0;
        if (mode == MODE_UP) begin
          idx_d  = idx_q + SEL_W'(1);
          wrap_d = (idx_q == IDX_TOP);
        end else begin
          idx_d  = idx_q - SEL_W'(1);
          wrap_d = (idx_q == '0);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!scan_mode) begin
      // Direct/pulse modes keep the counter cleared so a later scan starts fresh.
      cnt_d = '0;
    end

    if (!en) begin
      f_d = '0;
    end else if (mode == MODE_PULSE) begin
      f_d = load ? (OUT_W'(1) << sel) : '0;
    end else begin
      f_d = OUT_W'(1) << idx_d;
    end
  end

  // State registers; reset discards any scan or pulse in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      f_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      f_q    <= f_d;
      wrap_q <= wrap_d;
    end
  end

  assign F    = f_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

  // The output is never multi-hot.
  property p_onehot0;
    @(posedge clk) disable iff (rst) $onehot0(f_q);
  endproperty
  a_onehot0: assert property (p_onehot0);

  // MODE_DIRECT documents the encoding; direct and scan share the idx-driven output path.
  logic unused_mode_const;
  assign unused_mode_const = ^MODE_DIRECT;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Self-checking bench: two decoders (DWELL=4 and DWELL=1) share stimulus and
// are compared every cycle against a behavioural model of the decode rules.
module tb_onehot_scan_decoder;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;
  localparam int NINST = 2;

  logic clk;
  logic rst;
  logic en;
  logic [1:0] mode;
  logic [SEL_W-1:0] sel;
  logic load;

  logic [OUT_W-1:0] f0, f1;
  logic [SEL_W-1:0] idx0, idx1;
  logic wrap0, wrap1;

  int n_checks;
  int n_fail;

  // Model state, one entry per DUT instance.
  int dw [NINST];
  int m_idx [NINST];
  int m_cnt [NINST];
  int m_f [NINST];
  int m_wrap [NINST];

  onehot_scan_decoder #(.SEL_W(SEL_W), .DWELL(4)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .load(load),
    .F(f0), .idx(idx0), .wrap(wrap0)
  );

  onehot_scan_decoder #(.SEL_W(SEL_W), .DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .load(load),
    .F(f1), .idx(idx1), .wrap(wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NINST; k++) begin
      m_idx[k] = 0; m_cnt[k] = 0; m_f[k] = 0; m_wrap[k] = 0;
    end
  endtask

  // One rising edge of the reference behaviour, using the current inputs.
  task automatic model_edge();
    for (int k = 0; k < NINST; k++) begin
      m_wrap[k] = 0;
      if (load) begin
        m_idx[k] = int'(sel);
        m_cnt[k] = 0;
      end else if (mode >= 2 && en) begin
        if (m_cnt[k] == dw[k] - 1) begin
          m_cnt[k] = 0;
          if (mode == 2) begin
            m_wrap[k] = (m_idx[k] == OUT_W - 1) ? 1 : 0;
            m_idx[k] = (m_idx[k] + 1) % OUT_W;
          end else begin
            m_wrap[k] = (m_idx[k] == 0) ? 1 : 0;
            m_idx[k] = (m_idx[k] + OUT_W - 1) % OUT_W;
          end
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end else if (mode < 2) begin
        m_cnt[k] = 0;
      end
      if (!en)            m_f[k] = 0;
      else if (mode == 1) m_f[k] = load ? (1 << sel) : 0;
      else                m_f[k] = 1 << m_idx[k];
    end
  endtask

  task automatic compare_all();
    check("F_dw4",    int'(f0),    m_f[0]);
    check("idx_dw4",  int'(idx0),  m_idx[0]);
    check("wrap_dw4", int'(wrap0), m_wrap[0]);
    check("F_dw1",    int'(f1),    m_f[1]);
    check("idx_dw1",  int'(idx1),  m_idx[1]);
    check("wrap_dw1", int'(wrap1), m_wrap[1]);
  endtask

  // Advance one clock edge and compare both instances against the model.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Pulse reset asynchronously between clock edges and check the immediate effect.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_F",    int'(f0),    0);
    check("rst_idx",  int'(idx0),  0);
    check("rst_wrap", int'(wrap0), 0);
    compare_all();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    dw[0] = 4;
    dw[1] = 1;
    rst = 1'b1; en = 1'b0; mode = 2'b00; sel = '0; load = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;

    // Direct decode of every index, held while load is low.
    en = 1'b1; mode = 2'b00;
    for (int s = 0; s < OUT_W; s++) begin
      sel = SEL_W'(s); load = 1'b1;
      step();
      check("direct_F", int'(f0), 1 << s);
      load = 1'b0;
      step();
      check("direct_hold", int'(f0), 1 << s);
    end
    en = 1'b0;
    step();
    check("en_off_F", int'(f0), 0);
    check("en_off_idx", int'(idx0), 7);

    // Back-to-back pulses.
    en = 1'b1; mode = 2'b01;
    sel = 3'd3; load = 1'b1; step(); check("pulse_a", int'(f0), 8'h08);
    sel = 3'd5;              step(); check("pulse_b", int'(f0), 8'h20);
    load = 1'b0;             step(); check("pulse_end", int'(f0), 0);

    // Scan up from reset.
    #2;
    async_reset();
    mode = 2'b10; en = 1'b1;
    for (int e = 1; e <= 33; e++) begin
      step();
      if (e < 4)   check("up_first", int'(f0), 8'h01);
      if (e == 4)  check("up_e4", int'(f0), 8'h02);
      if (e == 8)  check("up_e8", int'(f0), 8'h04);
      if (e == 32) begin
        check("up_wrapF", int'(f0), 8'h01);
        check("up_wrap", int'(wrap0), 1);
      end
      if (e == 33) check("up_wrap_once", int'(wrap0), 0);
    end

    // Scan down with a load of 0, then a mid-dwell reload.
    mode = 2'b11; sel = 3'd0; load = 1'b1;
    step(); check("dn_load", int'(f0), 8'h01);
    load = 1'b0;
    for (int e = 1; e <= 4; e++) step();
    check("dn_idx", int'(idx0), 7);
    check("dn_F", int'(f0), 8'h80);
    check("dn_wrap", int'(wrap0), 1);
    step(); step();
    sel = 3'd4; load = 1'b1;
    step(); check("dn_reload", int'(f0), 8'h10);
    load = 1'b0;
    for (int e = 1; e <= 3; e++) step();
    check("dn_dwell", int'(idx0), 4);
    step(); check("dn_adv", int'(idx0), 3);

    // Enable gating mid-dwell.
    mode = 2'b10; sel = 3'd0; load = 1'b1; step();
    load = 1'b0; step(); step();
    en = 1'b0;
    for (int e = 0; e < 6; e++) begin
      step();
      check("gate_F", int'(f0), 0);
      check("gate_idx", int'(idx0), 0);
    end
    en = 1'b1;
    step(); check("resume_hold", int'(idx0), 0);
    step(); check("resume_adv", int'(idx0), 1);

    // Async reset mid-scan, then scan restarts.
    step(); step();
    #2;
    async_reset();
    step(); check("restart_F", int'(f0), 8'h01);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      load = ($urandom_range(0, 5) == 0);
      sel  = SEL_W'($urandom);
      if ($urandom_range(0, 199) == 0) async_reset();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
